// File: rtl/net_tx_arbiter_pkg.sv
// Shared types for the network-layer TX arbiter: packet word, arbiter state
// encoding and error-bit indices.
package net_tx_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic              last;
    logic [DATA_W-1:0] data;
  } PacketWord;

  typedef enum logic [1:0] {ARB_IDLE, ARB_USER, ARB_CTRL} ArbState;

  localparam int ARB_ERR_USR_LONG  = 0;
  localparam int ARB_ERR_CTRL_LONG = 1;

endpackage

// File: rtl/net_tx_out_stage.sv
// One-entry pipeline register carrying a PacketWord plus its controller flag.
// Handshake: a word moves on valid & ready at each side; in_ready is high when empty or draining.
module net_tx_out_stage
  import net_tx_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  PacketWord in_word_i,
  input  logic      in_ctrl_i,
  output logic      in_ready_o,
  output PacketWord out_word_o,
  output logic      out_ctrl_o,
  input  logic      out_ready_i
);

  PacketWord word_q;
  logic      ctrl_q;

  // Full throughput: a new word may enter in the same cycle the old one leaves.
  assign in_ready_o = ~word_q.valid | out_ready_i;
  assign out_word_o = word_q;
  assign out_ctrl_o = ctrl_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      ctrl_q <= 1'b0;
    end else if (in_word_i.valid && in_ready_o) begin
      word_q <= in_word_i;
      ctrl_q <= in_ctrl_i;
    end else if (out_ready_i) begin
      word_q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/net_tx_arbiter.sv
// Packet-granular arbiter between the user and router-controller TX streams.
// Valid/ready: a word transfers on any port in a cycle where its valid and ready are both high.
module net_tx_arbiter
  import net_tx_arbiter_pkg::*;
#(
  parameter int CTRL_PRIORITY = 1,
  parameter int MAX_PKT_WORDS = 256,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  PacketWord            usr_tx,
  output logic                 usr_tx_ready,
  input  PacketWord            ctrl_tx,
  output logic                 ctrl_tx_ready,
  output PacketWord            arb_tx,
  output logic                 arb_tx_ctrl,
  input  logic                 arb_tx_ready,
  output logic                 arb_busy,
  output logic [7:0]           arb_error,
  output logic [CNT_WIDTH-1:0] usr_pkt_cnt,
  output logic [CNT_WIDTH-1:0] ctrl_pkt_cnt
);

  localparam int WCNT_W = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(MAX_PKT_WORDS);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_PKT_WORDS - 1);

  ArbState              state_q;
  ArbState              last_grant_q;
  logic [WCNT_W-1:0]    wcnt_q;
  logic [CNT_WIDTH-1:0] usr_cnt_q;
  logic [CNT_WIDTH-1:0] ctrl_cnt_q;
  logic [1:0]           err_q;

  PacketWord sel_word;
  logic      stage_ready;
  logic      accept;

  // Grant mux: only the owning source reaches the output stage; IDLE forwards nothing.
  always_comb begin
    sel_word = '0;
    case (state_q)
      ARB_USER: sel_word = usr_tx;
      ARB_CTRL: sel_word = ctrl_tx;
      default:  sel_word = '0;
    endcase
  end

  assign accept        = sel_word.valid & stage_ready;
  assign usr_tx_ready  = (state_q == ARB_USER) & stage_ready;
  assign ctrl_tx_ready = (state_q == ARB_CTRL) & stage_ready;
  assign arb_busy      = (state_q != ARB_IDLE);
  assign arb_error     = {6'b0, err_q};
  assign usr_pkt_cnt   = usr_cnt_q;
  assign ctrl_pkt_cnt  = ctrl_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= ARB_CTRL;
      wcnt_q       <= '0;
      usr_cnt_q    <= '0;
      ctrl_cnt_q   <= '0;
      err_q        <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (ctrl_tx.valid && ((CTRL_PRIORITY != 0) || !usr_tx.valid ||
                                (last_grant_q == ARB_USER))) begin
            state_q <= ARB_CTRL;
            wcnt_q  <= '0;
          end else if (usr_tx.valid) begin
            state_q <= ARB_USER;
            wcnt_q  <= '0;
          end
        end
        ARB_USER, ARB_CTRL: begin
          if (accept) begin
            if (wcnt_q != WCNT_MAX) wcnt_q <= wcnt_q + 1'b1;
            if (sel_word.last) begin
              state_q      <= ARB_IDLE;
              last_grant_q <= state_q;
              if (state_q == ARB_CTRL) ctrl_cnt_q <= ctrl_cnt_q + 1'b1;
              else                     usr_cnt_q  <= usr_cnt_q + 1'b1;
            end else if (wcnt_q == WCNT_LAST) begin
              // Over-long packets keep the grant until 'last'; only the flag is raised.
              if (state_q == ARB_CTRL) err_q[ARB_ERR_CTRL_LONG] <= 1'b1;
              else                     err_q[ARB_ERR_USR_LONG]  <= 1'b1;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  net_tx_out_stage u_out_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_word_i   (sel_word),
    .in_ctrl_i   (state_q == ARB_CTRL),
    .in_ready_o  (stage_ready),
    .out_word_o  (arb_tx),
    .out_ctrl_o  (arb_tx_ctrl),
    .out_ready_i (arb_tx_ready)
  );

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Bench for net_tx_arbiter: instance 0 uses controller priority, instance 1 round-robin
// with 2-bit packet counters so counter wrap is reachable.
module tb_net_tx_arbiter;
  import net_tx_arbiter_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  PacketWord usr_tx [2];
  PacketWord ctrl_tx[2];
  PacketWord arb_tx [2];
  logic      usr_rdy[2], ctrl_rdy[2], arb_ctrl[2], arb_rdy[2], busy[2];
  logic [7:0]  err[2];
  logic [31:0] ucnt0, ccnt0;
  logic [1:0]  ucnt1, ccnt1;

  always #5 clk = ~clk;

  net_tx_arbiter #(.CTRL_PRIORITY(1), .MAX_PKT_WORDS(256), .CNT_WIDTH(32)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .usr_tx(usr_tx[0]), .usr_tx_ready(usr_rdy[0]),
    .ctrl_tx(ctrl_tx[0]), .ctrl_tx_ready(ctrl_rdy[0]),
    .arb_tx(arb_tx[0]), .arb_tx_ctrl(arb_ctrl[0]), .arb_tx_ready(arb_rdy[0]),
    .arb_busy(busy[0]), .arb_error(err[0]),
    .usr_pkt_cnt(ucnt0), .ctrl_pkt_cnt(ccnt0)
  );

  net_tx_arbiter #(.CTRL_PRIORITY(0), .MAX_PKT_WORDS(256), .CNT_WIDTH(2)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .usr_tx(usr_tx[1]), .usr_tx_ready(usr_rdy[1]),
    .ctrl_tx(ctrl_tx[1]), .ctrl_tx_ready(ctrl_rdy[1]),
    .arb_tx(arb_tx[1]), .arb_tx_ctrl(arb_ctrl[1]), .arb_tx_ready(arb_rdy[1]),
    .arb_busy(busy[1]), .arb_error(err[1]),
    .usr_pkt_cnt(ucnt1), .ctrl_pkt_cnt(ccnt1)
  );

  // Source word queues hold {last, data}; observed/expected hold {ctrl, last, data}.
  logic [32:0] usq[2][$];
  logic [32:0] csq[2][$];
  logic [33:0] obs_q[2][$];
  logic [33:0] exp_q[2][$];
  int          obs_cyc[2][$];
  int          uacc[2], cacc[2];
  int          mdl_ucnt[2], mdl_ccnt[2];
  bit          mdl_last_ctrl[2];
  int          cyc = 0;
  int          rdy_mode = 0;
  int          errors = 0;
  int          checks = 0;

  // ---------------- drivers ----------------
  task automatic drive_src();
    for (int d = 0; d < 2; d++) begin
      usr_tx[d]  = (usq[d].size() != 0) ? PacketWord'({1'b1, usq[d][0]}) : '0;
      ctrl_tx[d] = (csq[d].size() != 0) ? PacketWord'({1'b1, csq[d][0]}) : '0;
      case (rdy_mode)
        0:       arb_rdy[d] = 1'b1;
        1:       arb_rdy[d] = (cyc % 2 == 0);
        default: arb_rdy[d] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // One clock: sample handshakes before the edge, update sources after it.
  task automatic step();
    bit ufire[2], cfire[2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ufire[d] = usr_tx[d].valid & usr_rdy[d];
      cfire[d] = ctrl_tx[d].valid & ctrl_rdy[d];
      if (arb_tx[d].valid && arb_rdy[d]) begin
        obs_q[d].push_back({arb_ctrl[d], arb_tx[d].last, arb_tx[d].data});
        obs_cyc[d].push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (ufire[d] && usq[d].size() != 0) begin void'(usq[d].pop_front()); uacc[d]++; end
      if (cfire[d] && csq[d].size() != 0) begin void'(csq[d].pop_front()); cacc[d]++; end
    end
    drive_src();
  endtask

  task automatic add_pkt(input int d, input bit is_ctrl, input int len);
    for (int i = 0; i < len; i++) begin
      logic [32:0] w;
      w = {(i == len - 1), 32'($urandom)};
      if (is_ctrl) csq[d].push_back(w);
      else         usq[d].push_back(w);
    end
  endtask

  task automatic drain(input string name);
    int budget = 3000;
    while (budget > 0 && (usq[0].size() + usq[1].size() + csq[0].size() + csq[1].size() != 0 ||
           busy[0] || busy[1] || arb_tx[0].valid || arb_tx[1].valid)) begin
      step();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL %s_drain: got timeout after 3000 cycles, required idle", name);
    end
  endtask

  task automatic flush_all();
    for (int d = 0; d < 2; d++) begin
      usq[d].delete(); csq[d].delete(); obs_q[d].delete(); exp_q[d].delete(); obs_cyc[d].delete();
      mdl_ucnt[d] = 0; mdl_ccnt[d] = 0; mdl_last_ctrl[d] = 1'b1;
    end
  endtask

  // ---------------- reference model ----------------
  // Packet-level view: with all packets queued up front, each grant decision picks a whole
  // packet from the pending lists by the priority / round-robin rule.
  task automatic model_run(input int d);
    logic [32:0] u[$];
    logic [32:0] c[$];
    logic [32:0] w;
    bit prio, pick_c;
    u = usq[d]; c = csq[d];
    prio = (d == 0);
    while (u.size() != 0 || c.size() != 0) begin
      pick_c = (c.size() != 0) && (prio || u.size() == 0 || !mdl_last_ctrl[d]);
      do begin
        w = pick_c ? c.pop_front() : u.pop_front();
        exp_q[d].push_back({pick_c, w});
      end while (!w[32]);
      mdl_last_ctrl[d] = pick_c;
      if (pick_c) mdl_ccnt[d]++;
      else        mdl_ucnt[d]++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    flush_all();
    drive_src();
    step(); step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({arb_tx[d].valid, arb_ctrl[d], usr_rdy[d], ctrl_rdy[d], busy[d], err[d]} !== 13'b0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got %b required 0", d,
                 {arb_tx[d].valid, arb_ctrl[d], usr_rdy[d], ctrl_rdy[d], busy[d], err[d]});
      end
    end
    checks++;
    if ({ucnt0, ccnt0, ucnt1, ccnt1} !== 68'b0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d/%0d/%0d required 0", ucnt0, ccnt0, ucnt1, ccnt1);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_user();
    int c0;
    rdy_mode = 0;
    add_pkt(0, 1'b0, 3);
    model_run(0);
    drive_src();
    c0 = cyc;
    step();
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++; $display("FAIL t1_busy: got %b required 1", busy[0]);
    end
    drain("t1");
    checks++;
    if (obs_cyc[0].size() != 3 || obs_cyc[0][0] != c0 + 2 || obs_cyc[0][2] != c0 + 4) begin
      errors++;
      $display("FAIL t1_latency: got %0d words, first at +%0d, required 3 words at +2..+4",
               obs_cyc[0].size(), (obs_cyc[0].size() != 0) ? obs_cyc[0][0] - c0 : -1);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_q[d].size() != exp_q[d].size()) begin
        errors++; $display("FAIL t1_len inst%0d: got %0d required %0d", d, obs_q[d].size(), exp_q[d].size());
      end
      for (int i = 0; i < obs_q[d].size() && i < exp_q[d].size(); i++) begin
        checks++;
        if (obs_q[d][i] !== exp_q[d][i]) begin
          errors++; $display("FAIL t1_word%0d inst%0d: got %h required %h", i, d, obs_q[d][i], exp_q[d][i]);
        end
      end
      obs_q[d].delete(); exp_q[d].delete(); obs_cyc[d].delete();
    end
    checks++;
    if (ucnt0 !== 32'(mdl_ucnt[0])) begin
      errors++; $display("FAIL t1_usr_cnt: got %0d required %0d", ucnt0, mdl_ucnt[0]);
    end
  endtask

  task automatic test_contention();
    rdy_mode = 2;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 5; p++) add_pkt(d, 1'b0, $urandom_range(1, 5));
      for (int p = 0; p < 4; p++) add_pkt(d, 1'b1, $urandom_range(1, 5));
      model_run(d);
    end
    drive_src();
    drain("t2");
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_q[d].size() != exp_q[d].size()) begin
        errors++; $display("FAIL t2_len inst%0d: got %0d required %0d", d, obs_q[d].size(), exp_q[d].size());
      end
      for (int i = 0; i < obs_q[d].size() && i < exp_q[d].size(); i++) begin
        checks++;
        if (obs_q[d][i] !== exp_q[d][i]) begin
          errors++; $display("FAIL t2_word%0d inst%0d: got %h required %h", i, d, obs_q[d][i], exp_q[d][i]);
        end
      end
      obs_q[d].delete(); exp_q[d].delete(); obs_cyc[d].delete();
    end
    checks++;
    if ({ucnt0, ccnt0} !== {32'(mdl_ucnt[0]), 32'(mdl_ccnt[0])}) begin
      errors++; $display("FAIL t2_cnt_prio: got %0d/%0d required %0d/%0d", ucnt0, ccnt0, mdl_ucnt[0], mdl_ccnt[0]);
    end
    checks++;
    if ({ucnt1, ccnt1} !== {2'(mdl_ucnt[1]), 2'(mdl_ccnt[1])}) begin
      errors++; $display("FAIL t2_cnt_wrap: got %0d/%0d required %0d/%0d", ucnt1, ccnt1,
                         mdl_ucnt[1] % 4, mdl_ccnt[1] % 4);
    end
  endtask

  task automatic test_ctrl_stall();
    int target, budget, viol;
    rdy_mode = 1;
    add_pkt(0, 1'b1, 4);
    add_pkt(0, 1'b0, 2);
    model_run(0);
    drive_src();
    target = cacc[0] + 4;
    budget = 200;
    viol = 0;
    while (cacc[0] < target && budget > 0) begin
      step();
      budget--;
      if (usr_rdy[0] !== 1'b0) viol++;
    end
    checks++;
    if (viol != 0 || budget == 0) begin
      errors++; $display("FAIL t3_usr_ready: got %0d cycles with ready high (budget %0d), required 0", viol, budget);
    end
    drain("t3");
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_q[d].size() != exp_q[d].size()) begin
        errors++; $display("FAIL t3_len inst%0d: got %0d required %0d", d, obs_q[d].size(), exp_q[d].size());
      end
      for (int i = 0; i < obs_q[d].size() && i < exp_q[d].size(); i++) begin
        checks++;
        if (obs_q[d][i] !== exp_q[d][i]) begin
          errors++; $display("FAIL t3_word%0d inst%0d: got %h required %h", i, d, obs_q[d][i], exp_q[d][i]);
        end
      end
      obs_q[d].delete(); exp_q[d].delete(); obs_cyc[d].delete();
    end
  endtask

  task automatic test_overlong();
    int base, budget;
    rdy_mode = 0;
    add_pkt(0, 1'b0, 300);
    model_run(0);
    drive_src();
    base = uacc[0];
    budget = 1000;
    while (uacc[0] < base + 255 && budget > 0) begin step(); budget--; end
    checks++;
    if (err[0] !== 8'h00 || budget == 0) begin
      errors++; $display("FAIL t4_err_before: got %h at word %0d, required 00 at word 255", err[0], uacc[0] - base);
    end
    while (uacc[0] < base + 256 && budget > 0) begin step(); budget--; end
    checks++;
    if (err[0] !== 8'h01 || budget == 0) begin
      errors++; $display("FAIL t4_err_at256: got %h at word %0d, required 01 at word 256", err[0], uacc[0] - base);
    end
    drain("t4");
    checks++;
    if (obs_q[0].size() != exp_q[0].size()) begin
      errors++; $display("FAIL t4_len: got %0d required %0d", obs_q[0].size(), exp_q[0].size());
    end
    for (int i = 0; i < obs_q[0].size() && i < exp_q[0].size(); i++) begin
      checks++;
      if (obs_q[0][i] !== exp_q[0][i]) begin
        errors++; $display("FAIL t4_word%0d: got %h required %h", i, obs_q[0][i], exp_q[0][i]);
      end
    end
    obs_q[0].delete(); exp_q[0].delete(); obs_cyc[0].delete();
    checks++;
    if (err[0] !== 8'h01 || ucnt0 !== 32'(mdl_ucnt[0])) begin
      errors++; $display("FAIL t4_after: got err %h cnt %0d required 01 cnt %0d", err[0], ucnt0, mdl_ucnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    int base, budget;
    rdy_mode = 0;
    add_pkt(0, 1'b0, 5);
    drive_src();
    base = uacc[0];
    budget = 100;
    while (uacc[0] < base + 2 && budget > 0) begin step(); budget--; end
    rst_n = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({arb_tx[d].valid, arb_ctrl[d], usr_rdy[d], ctrl_rdy[d], busy[d], err[d]} !== 13'b0 || budget == 0) begin
        errors++;
        $display("FAIL t5_reset_outputs inst%0d: got %b required 0", d,
                 {arb_tx[d].valid, arb_ctrl[d], usr_rdy[d], ctrl_rdy[d], busy[d], err[d]});
      end
    end
    checks++;
    if ({ucnt0, ccnt0, ucnt1, ccnt1} !== 68'b0) begin
      errors++; $display("FAIL t5_reset_counters: got %0d/%0d/%0d/%0d required 0", ucnt0, ccnt0, ucnt1, ccnt1);
    end
    flush_all();
    drive_src();
    rst_n = 1'b1;
    step();
    add_pkt(0, 1'b0, 3);
    model_run(0);
    drive_src();
    drain("t5");
    checks++;
    if (obs_q[0].size() != exp_q[0].size()) begin
      errors++; $display("FAIL t5_len: got %0d required %0d", obs_q[0].size(), exp_q[0].size());
    end
    for (int i = 0; i < obs_q[0].size() && i < exp_q[0].size(); i++) begin
      checks++;
      if (obs_q[0][i] !== exp_q[0][i]) begin
        errors++; $display("FAIL t5_word%0d: got %h required %h", i, obs_q[0][i], exp_q[0][i]);
      end
    end
    obs_q[0].delete(); exp_q[0].delete(); obs_cyc[0].delete();
    checks++;
    if (ucnt0 !== 32'(mdl_ucnt[0])) begin
      errors++; $display("FAIL t5_usr_cnt: got %0d required %0d", ucnt0, mdl_ucnt[0]);
    end
  endtask

  task automatic test_back_to_back();
    rdy_mode = 0;
    for (int p = 0; p < 6; p++) add_pkt(0, 1'b1, 1);
    model_run(0);
    drive_src();
    drain("t6");
    for (int i = 1; i < obs_cyc[0].size(); i++) begin
      checks++;
      if (obs_cyc[0][i] - obs_cyc[0][i-1] != 2) begin
        errors++; $display("FAIL t6_spacing%0d: got %0d cycles required 2", i, obs_cyc[0][i] - obs_cyc[0][i-1]);
      end
    end
    checks++;
    if (obs_q[0].size() != exp_q[0].size()) begin
      errors++; $display("FAIL t6_len: got %0d required %0d", obs_q[0].size(), exp_q[0].size());
    end
    for (int i = 0; i < obs_q[0].size() && i < exp_q[0].size(); i++) begin
      checks++;
      if (obs_q[0][i] !== exp_q[0][i]) begin
        errors++; $display("FAIL t6_word%0d: got %h required %h", i, obs_q[0][i], exp_q[0][i]);
      end
    end
    obs_q[0].delete(); exp_q[0].delete(); obs_cyc[0].delete();
    checks++;
    if (ccnt0 !== 32'(mdl_ccnt[0])) begin
      errors++; $display("FAIL t6_ctrl_cnt: got %0d required %0d", ccnt0, mdl_ccnt[0]);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      usr_tx[d] = '0; ctrl_tx[d] = '0; arb_rdy[d] = 1'b1;
      uacc[d] = 0; cacc[d] = 0;
    end
    test_reset();
    test_single_user();
    test_contention();
    test_ctrl_stall();
    test_overlong();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
